// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequencer for a radix-2 DIT FFT memory block.
// Drives a ping-pong RAM pair (RAM1/RAM2), the write-data muxes, the
// read-bank mux, the even/odd demux and the twiddle ROM.
// Sequence: LOAD (bit-reversed writes into RAM1), then log2(N) butterfly
// stages alternating source/destination bank, then a one-cycle DONE pulse.
// Optional feature macro: FFT_SEQ_CTRL_ABORT_EN adds the i_abort input.
//
// Load handshake: a sample is consumed on every cycle where o_load_ready and
// i_load_valid are both high; i_load_valid is ignored whenever o_load_ready
// is low, and gaps (valid low while ready high) are allowed.
module fft_seq_ctrl #(
  parameter int N        = 16,
  parameter int BFLY_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_load_valid,
`ifdef FFT_SEQ_CTRL_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_load_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_result_bank,
  output logic [$clog2(N)-1:0] o_stage,
  output logic [1:0]           o_wr_src,
  output logic                 o_wr_en1,
  output logic                 o_wr_en2,
  output logic [$clog2(N)-1:0] o_wr_addr,
  output logic                 o_rd_en,
  output logic                 o_rd_sel,
  output logic [$clog2(N)-1:0] o_rd_addr,
  output logic                 o_eo_sel,
  output logic                 o_twi_rd_en,
  output logic [$clog2(N)-2:0] o_twi_addr
);

  localparam int A  = $clog2(N);
  localparam int S  = $clog2(N);
  // Cycles per stage: N reads, then the pipeline drains the last bot write.
  localparam int L  = N + 3 + BFLY_LAT;
  // Read-to-write distance: one cycle of RAM read latency, the butterfly,
  // and the top/bot write slots.
  localparam int D  = BFLY_LAT + 3;
  localparam int CW = $clog2(L);
  localparam logic RES_BANK = 1'(S % 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STAGE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [A-1:0]    r_cnt;
  logic [A-1:0]    r_stage;
  logic [CW-1:0]   r_cyc;
  logic            r_result_bank;

  // Address/flag pipeline from read issue to destination write.
  logic            r_pv    [D];
  logic            r_podd  [D];
  logic [A-1:0]    r_paddr [D];

  logic            w_abort;
  logic            w_rd_act;
  logic            w_odd;
  logic            w_last_cyc;
  logic [A-1:0]    w_k;
  logic [A-1:0]    w_half;
  logic [A-1:0]    w_mask;
  logic [A-1:0]    w_e;
  logic [A-1:0]    w_o;
  logic [A-1:0]    w_sh;

`ifdef FFT_SEQ_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [A-1:0] bitrev(input logic [A-1:0] v);
    logic [A-1:0] r;
    for (int b = 0; b < A; b++) r[b] = v[A-1-b];
    return r;
  endfunction

  // Butterfly k = cycle/2; even/odd element addresses are k with a zero
  // inserted at bit position s (even) plus the half offset (odd).
  assign w_rd_act   = (r_state == ST_STAGE) && (r_cyc < CW'(N));
  assign w_odd      = r_cyc[0];
  assign w_last_cyc = (r_cyc == CW'(L - 1));
  assign w_k        = A'(r_cyc >> 1);
  assign w_half     = A'(1) << r_stage;
  assign w_mask     = w_half - A'(1);
  assign w_e        = ((w_k & ~w_mask) << 1) | (w_k & w_mask);
  assign w_o        = w_e | w_half;
  assign w_sh       = A'(S - 1) - r_stage;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Load counter, stage cycle counter, stage index and result-bank hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_cyc         <= '0;
      r_stage       <= '0;
      r_result_bank <= 1'b0;
    end else begin
      if (r_state == ST_LOAD && i_load_valid) r_cnt <= r_cnt + A'(1);
      else if (r_state != ST_LOAD)            r_cnt <= '0;

      if (w_next_state != ST_STAGE) begin
        r_cyc   <= '0;
        r_stage <= '0;
      end else if (r_state == ST_STAGE) begin
        if (w_last_cyc) begin
          r_cyc   <= '0;
          r_stage <= r_stage + A'(1);
        end else begin
          r_cyc   <= r_cyc + CW'(1);
        end
      end

      if (r_state == ST_DONE)                              r_result_bank <= RES_BANK;
      else if (r_state == ST_IDLE && w_next_state == ST_LOAD) r_result_bank <= 1'b0;
    end
  end

  // Shift read address/odd flag toward the write port; flushed outside STAGE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        r_pv[i]    <= 1'b0;
        r_podd[i]  <= 1'b0;
        r_paddr[i] <= '0;
      end
    end else if (r_state != ST_STAGE || w_abort) begin
      for (int i = 0; i < D; i++) r_pv[i] <= 1'b0;
    end else begin
      r_pv[0]    <= w_rd_act;
      r_podd[0]  <= w_odd;
      r_paddr[0] <= w_odd ? w_o : w_e;
      for (int i = 1; i < D; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_podd[i]  <= r_podd[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  // Next-state and output decode; every enable is gated by state.
  always_comb begin
    w_next_state  = r_state;
    o_load_ready  = 1'b0;
    o_busy        = (r_state != ST_IDLE);
    o_done        = 1'b0;
    o_result_bank = r_result_bank;
    o_stage       = r_stage;
    o_wr_src      = 2'b00;
    o_wr_en1      = 1'b0;
    o_wr_en2      = 1'b0;
    o_wr_addr     = '0;
    o_rd_en       = 1'b0;
    o_rd_sel      = 1'b0;
    o_rd_addr     = '0;
    o_eo_sel      = 1'b0;
    o_twi_rd_en   = 1'b0;
    o_twi_addr    = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !w_abort) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          o_wr_en1  = 1'b1;
          o_wr_addr = bitrev(r_cnt);
        end
        if (w_abort)                                      w_next_state = ST_IDLE;
        else if (i_load_valid && r_cnt == A'(N - 1))      w_next_state = ST_STAGE;
      end
      ST_STAGE: begin
        if (w_rd_act) begin
          o_rd_en   = 1'b1;
          o_rd_sel  = r_stage[0];
          o_rd_addr = w_odd ? w_o : w_e;
          if (w_odd) begin
            o_twi_rd_en = 1'b1;
            o_twi_addr  = (A-1)'((w_k & w_mask) << w_sh);
          end
        end
        o_eo_sel = r_pv[0] & r_podd[0];
        if (r_pv[D-1]) begin
          // Destination is the bank not being read this stage.
          o_wr_en1  = r_stage[0];
          o_wr_en2  = ~r_stage[0];
          o_wr_src  = r_podd[D-1] ? 2'b10 : 2'b01;
          o_wr_addr = r_paddr[D-1];
        end
        if (w_abort)                                      w_next_state = ST_IDLE;
        else if (w_last_cyc && r_stage == A'(S - 1))      w_next_state = ST_DONE;
      end
      ST_DONE: begin
        o_done        = 1'b1;
        o_result_bank = RES_BANK;
        w_next_state  = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl (N=8, BFLY_LAT=2).
// A negedge recorder logs every write, read, odd-flag and done event with its
// cycle stamp; each test builds the expected event list from the FFT
// addressing rules and compares the two lists.
module tb_fft_seq_ctrl;

  localparam int N  = 8;
  localparam int BL = 2;
  localparam int A  = $clog2(N);
  localparam int S  = A;
  localparam int L  = N + 3 + BL;
  localparam int W  = 32;

  logic clk, rst, i_start, i_load_valid;
`ifdef FFT_SEQ_CTRL_ABORT_EN
  logic i_abort;
`endif
  logic         o_load_ready, o_busy, o_done, o_result_bank;
  logic [A-1:0] o_stage, o_wr_addr, o_rd_addr;
  logic [1:0]   o_wr_src;
  logic         o_wr_en1, o_wr_en2, o_rd_en, o_rd_sel, o_eo_sel, o_twi_rd_en;
  logic [A-2:0] o_twi_addr;
  logic [4*A+10:0] all_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];
  int ld_stamps[$];

  fft_seq_ctrl #(.N(N), .BFLY_LAT(BL)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_load_valid  (i_load_valid),
`ifdef FFT_SEQ_CTRL_ABORT_EN
    .i_abort       (i_abort),
`endif
    .o_load_ready  (o_load_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_result_bank (o_result_bank),
    .o_stage       (o_stage),
    .o_wr_src      (o_wr_src),
    .o_wr_en1      (o_wr_en1),
    .o_wr_en2      (o_wr_en2),
    .o_wr_addr     (o_wr_addr),
    .o_rd_en       (o_rd_en),
    .o_rd_sel      (o_rd_sel),
    .o_rd_addr     (o_rd_addr),
    .o_eo_sel      (o_eo_sel),
    .o_twi_rd_en   (o_twi_rd_en),
    .o_twi_addr    (o_twi_addr)
  );

  assign all_out = {o_load_ready, o_busy, o_done, o_result_bank, o_stage, o_wr_src,
                    o_wr_en1, o_wr_en2, o_wr_addr, o_rd_en, o_rd_sel, o_rd_addr,
                    o_eo_sel, o_twi_rd_en, o_twi_addr};

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event encoding: {pad, cycle stamp, kind, payload}; kind 0 wr, 1 rd, 2 odd, 3 done.
  function automatic logic [W-1:0] mk_ev(input int t, input int kind, input logic [11:0] p);
    logic [15:0] ts;
    logic [1:0]  kd;
    ts = t[15:0];
    kd = kind[1:0];
    return {2'b00, ts, kd, p};
  endfunction

  // Recorder: samples outputs mid-cycle.
  always @(negedge clk) begin
    if (o_wr_en1 || o_wr_en2)
      obs_q.push_back(mk_ev(cyc, 0, 12'({o_wr_en1, o_wr_en2, o_wr_src, o_wr_addr})));
    if (o_rd_en || o_twi_rd_en)
      obs_q.push_back(mk_ev(cyc, 1, 12'({o_rd_en, o_rd_sel, o_twi_rd_en, o_twi_addr, o_rd_addr})));
    if (o_eo_sel) obs_q.push_back(mk_ev(cyc, 2, 12'(0)));
    if (o_done)   obs_q.push_back(mk_ev(cyc, 3, 12'(0)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [A-1:0] rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < A; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return A'(r);
  endfunction

  function automatic void push_exp(input int t, input int kind, input logic [11:0] p, input int cut);
    if (t <= cut) exp_q.push_back(mk_ev(t, kind, p));
  endfunction

  // Expected events of one transform whose last load write is at t_last,
  // keeping only events at or before cycle 'cut'.
  function automatic void build_exp(input int t_last, input int cut);
    exp_q.delete();
    foreach (ld_stamps[i])
      push_exp(ld_stamps[i], 0, 12'({1'b1, 1'b0, 2'b00, rev(i)}), cut);
    for (int s = 0; s < S; s++) begin
      int t0, half;
      logic sb;
      t0   = t_last + 1 + s * L;
      half = 1 << s;
      sb   = ((s % 2) == 1);
      for (int k = 0; k < N / 2; k++) begin
        int g, j, e, o, tw;
        g  = k / half;
        j  = k % half;
        e  = g * 2 * half + j;
        o  = e + half;
        tw = j * (1 << (S - 1 - s));
        push_exp(t0 + 2*k,          1, 12'({1'b1, sb, 1'b0, (A-1)'(0),  A'(e)}), cut);
        push_exp(t0 + 2*k + 1,      1, 12'({1'b1, sb, 1'b1, (A-1)'(tw), A'(o)}), cut);
        push_exp(t0 + 2*k + 2,      2, 12'(0), cut);
        push_exp(t0 + 2*k + 3 + BL, 0, 12'({sb, ~sb, 2'b01, A'(e)}), cut);
        push_exp(t0 + 2*k + 4 + BL, 0, 12'({sb, ~sb, 2'b10, A'(o)}), cut);
      end
    end
    push_exp(t_last + 1 + S * L, 3, 12'(0), cut);
    exp_q.sort();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_load_valid = 1'b0;
`ifdef FFT_SEQ_CTRL_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (2) tick();
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    tick();
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL idle_after_reset: got %h want 0", all_out);
    end
  endtask

  // gap < 0 selects random gaps; noise toggles i_start/i_load_valid where ignored.
  task automatic test_full_run(input int gap, input bit noise);
    int t_last, d0, n;
    obs_q.delete();
    ld_stamps.delete();
    i_start = 1'b1;
    i_load_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    i_start = 1'b0; i_load_valid = 1'b0;
    total++;
    if (o_load_ready !== 1'b1 || o_busy !== 1'b1) begin
      bad++; $display("FAIL load_entry: ready=%b busy=%b want 1 1", o_load_ready, o_busy);
    end
    for (int i = 0; i < N; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int c = 0; c < g; c++) begin
        i_load_valid = 1'b0;
        i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_load_valid = 1'b1;
      ld_stamps.push_back(cyc);
      tick();
    end
    i_load_valid = 1'b0; i_start = 1'b0;
    t_last = ld_stamps[N-1];
    d0 = t_last + 1 + S * L;
    while (cyc < d0 + 1) begin
      if (noise && cyc < d0 - 1) begin
        i_start      = 1'($urandom_range(0, 1));
        i_load_valid = 1'($urandom_range(0, 1));
      end else begin
        i_start = 1'b0; i_load_valid = 1'b0;
      end
      tick();
    end
    i_start = 1'b0; i_load_valid = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL busy_after_done: got %b want 0", o_busy);
    end
    total++;
    if (o_result_bank !== 1'(S % 2)) begin
      bad++; $display("FAIL result_bank: got %b want %b", o_result_bank, 1'(S % 2));
    end
    build_exp(t_last, 32'h7fffffff);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL run_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL run_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stage();
    int t_last, t_rst, n;
    obs_q.delete();
    ld_stamps.delete();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_load_valid = 1'b1;
      ld_stamps.push_back(cyc);
      tick();
    end
    i_load_valid = 1'b0;
    t_last = ld_stamps[N-1];
    repeat (L + 3) tick();
    total++;
    if (o_rd_en !== 1'b1 || o_stage !== A'(1)) begin
      bad++; $display("FAIL mid_stage_reach: rd_en=%b stage=%0d want 1 1", o_rd_en, o_stage);
    end
    t_rst = cyc;
    rst = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_mid_stage_outputs: got %h want 0", all_out);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2 * L; c++) begin
      i_load_valid = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (o_busy !== 1'b0) begin
        bad++; $display("FAIL idle_after_mid_reset: busy=%b want 0 at cycle %0d", o_busy, cyc);
      end
    end
    i_load_valid = 1'b0;
    build_exp(t_last, t_rst - 1);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL reset_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL reset_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef FFT_SEQ_CTRL_ABORT_EN
  task automatic test_abort();
    int t_last, t_ab, n;
    obs_q.delete();
    ld_stamps.delete();
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_priority: busy=%b want 0", o_busy);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_load_valid = 1'b1;
      ld_stamps.push_back(cyc);
      tick();
    end
    i_load_valid = 1'b0;
    t_last = ld_stamps[N-1];
    t_ab = t_last + 1 + L + 5;
    while (cyc < t_ab) tick();
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy: got %b want 0", o_busy);
    end
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL abort_outputs: got %h want 0", all_out);
    end
    for (int c = 0; c < 2 * L; c++) begin
      i_load_valid = 1'($urandom_range(0, 1));
      tick();
    end
    i_load_valid = 1'b0;
    build_exp(t_last, t_ab);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; i_start = 1'b0; i_load_valid = 1'b0;
`ifdef FFT_SEQ_CTRL_ABORT_EN
    i_abort = 1'b0;
`endif
    test_reset();
    test_full_run(2, 1'b0);
    test_full_run(-1, 1'b1);
    test_reset_mid_stage();
`ifdef FFT_SEQ_CTRL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
